// File: rtl/rs_station_param_if.sv
// rs_station_param_if: dispatch, CDB snoop, status and issue bus of the reservation station.
// Latency: wires only, no state.
// Backpressure: issue_ready_in from the execution unit stalls the issue register.
// Ports: master = dispatcher/ROB/execution-unit side, slave = station side.
interface rs_station_param_if #(
  parameter int DEPTH   = 8,
  parameter int XLEN    = 32,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  // dispatch
  logic                      disp_en_in;
  logic [OP_W-1:0]           disp_opcode_in;
  logic [ROB_W-1:0]          disp_qj_in;
  logic [ROB_W-1:0]          disp_qk_in;
  logic [XLEN-1:0]           disp_vj_in;
  logic [XLEN-1:0]           disp_vk_in;
  logic [XLEN-1:0]           disp_imm_in;
  logic [XLEN-1:0]           disp_pc_in;
  logic [ROB_W-1:0]          disp_dest_in;
  // occupancy status
  logic                      full_out;
  logic                      almost_full_out;
  logic [CW-1:0]             count_out;
  // CDB snoop, channel c at [c*W +: W]
  logic [NUM_CDB-1:0]        cdb_valid_in;
  logic [NUM_CDB*ROB_W-1:0]  cdb_tag_in;
  logic [NUM_CDB*XLEN-1:0]   cdb_data_in;
  // issue
  logic                      issue_valid_out;
  logic                      issue_ready_in;
  logic [OP_W-1:0]           issue_opcode_out;
  logic [XLEN-1:0]           issue_vj_out;
  logic [XLEN-1:0]           issue_vk_out;
  logic [XLEN-1:0]           issue_imm_out;
  logic [XLEN-1:0]           issue_pc_out;
  logic [ROB_W-1:0]          issue_dest_out;

  modport master (
    output disp_en_in, disp_opcode_in, disp_qj_in, disp_qk_in, disp_vj_in, disp_vk_in,
           disp_imm_in, disp_pc_in, disp_dest_in,
           cdb_valid_in, cdb_tag_in, cdb_data_in, issue_ready_in,
    input  full_out, almost_full_out, count_out,
           issue_valid_out, issue_opcode_out, issue_vj_out, issue_vk_out,
           issue_imm_out, issue_pc_out, issue_dest_out
  );

  modport slave (
    input  disp_en_in, disp_opcode_in, disp_qj_in, disp_qk_in, disp_vj_in, disp_vk_in,
           disp_imm_in, disp_pc_in, disp_dest_in,
           cdb_valid_in, cdb_tag_in, cdb_data_in, issue_ready_in,
    output full_out, almost_full_out, count_out,
           issue_valid_out, issue_opcode_out, issue_vj_out, issue_vk_out,
           issue_imm_out, issue_pc_out, issue_dest_out
  );
endinterface

// File: rtl/rs_station_param.sv
// rs_station_param: DEPTH-entry ALU reservation station snooping NUM_CDB result buses, oldest-ready issue.
// Latency: dispatch with ready operands -> issue_valid_out two edges later; wakeup -> selectable next edge.
// Backpressure: issue register holds stable while issue_valid_out & !issue_ready_in; full_out blocks dispatch.
// Ports: clk_in, rst_n_in (sync, active low), rdy_in (global freeze), flush_in (kill all),
//        bus (slave modport): dispatch fields, CDB snoop channels, issue handshake, occupancy status.
module rs_station_param #(
  parameter int DEPTH    = 8,
  parameter int XLEN     = 32,
  parameter int ROB_W    = 4,
  parameter int OP_W     = 6,
  parameter int NUM_CDB  = 2,
  parameter int AFULL_TH = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  rs_station_param_if.slave bus
);
  localparam int   CW        = $clog2(DEPTH + 1);
  localparam int   IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic AFULL_RST = (DEPTH <= AFULL_TH);

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [ROB_W-1:0] dest;
  } ent_t;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [ROB_W-1:0] dest;
  } iss_t;

  ent_t             ent_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  // older_q[i][j] = 1 means entry i was dispatched before entry j. Only rows and
  // columns of valid entries are meaningful; a slot's row/column is rewritten on dispatch.
  logic [DEPTH-1:0] older_q [DEPTH];
  iss_t             iss_q;
  logic             iss_vld_q;
  logic [CW-1:0]    count_q;
  logic             full_q;
  logic             afull_q;

  logic [DEPTH-1:0] ready_v;
  logic [DEPTH-1:0] sel_oh;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    free_idx;
  logic             any_ready;
  logic             disp_acc;
  logic             issue_fire;
  ent_t             disp_ent;
  logic [CW-1:0]    count_d;
  logic             full_d;
  logic             afull_d;

  // Oldest-ready select: an entry wins if it is older than every other ready entry.
  always_comb begin
    ready_v = '0;
    sel_oh  = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      ready_v[i] = valid_q[i] && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = ready_v[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready_v[j] && !older_q[i][j]) sel_oh[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (sel_oh[i]) sel_idx = IW'(i);
  end

  assign any_ready = |ready_v;

  // Lowest-index free slot; uses registered valid bits so a slot freed this edge is not reused.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IW'(i);
  end

  // Dispatch payload with same-cycle CDB capture; descending scan lets the lowest channel win.
  always_comb begin
    disp_ent.opcode = bus.disp_opcode_in;
    disp_ent.qj     = bus.disp_qj_in;
    disp_ent.qk     = bus.disp_qk_in;
    disp_ent.vj     = bus.disp_vj_in;
    disp_ent.vk     = bus.disp_vk_in;
    disp_ent.imm    = bus.disp_imm_in;
    disp_ent.pc     = bus.disp_pc_in;
    disp_ent.dest   = bus.disp_dest_in;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (bus.cdb_valid_in[c] && bus.disp_qj_in != '0 &&
          bus.cdb_tag_in[c*ROB_W +: ROB_W] == bus.disp_qj_in) begin
        disp_ent.vj = bus.cdb_data_in[c*XLEN +: XLEN];
        disp_ent.qj = '0;
      end
      if (bus.cdb_valid_in[c] && bus.disp_qk_in != '0 &&
          bus.cdb_tag_in[c*ROB_W +: ROB_W] == bus.disp_qk_in) begin
        disp_ent.vk = bus.cdb_data_in[c*XLEN +: XLEN];
        disp_ent.qk = '0;
      end
    end
  end

  assign disp_acc   = bus.disp_en_in && !full_q && !flush_in;
  assign issue_fire = (!iss_vld_q || bus.issue_ready_in) && any_ready && !flush_in;
  assign count_d    = count_q + CW'(disp_acc) - CW'(issue_fire);
  assign full_d     = (count_d == CW'(DEPTH));
  assign afull_d    = ((DEPTH - int'(count_d)) <= AFULL_TH);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
      valid_q   <= '0;
      iss_q     <= '0;
      iss_vld_q <= 1'b0;
      count_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= AFULL_RST;
    end else if (rdy_in) begin
      if (flush_in) begin
        // Issue payload is left as is; only the valid bit matters once killed.
        valid_q   <= '0;
        iss_vld_q <= 1'b0;
        count_q   <= '0;
        full_q    <= 1'b0;
        afull_q   <= AFULL_RST;
      end else begin
        // Wakeup: descending scan so the lowest matching channel's data lands last.
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i]) begin
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
              if (bus.cdb_valid_in[c]) begin
                if (ent_q[i].qj != '0 && ent_q[i].qj == bus.cdb_tag_in[c*ROB_W +: ROB_W]) begin
                  ent_q[i].vj <= bus.cdb_data_in[c*XLEN +: XLEN];
                  ent_q[i].qj <= '0;
                end
                if (ent_q[i].qk != '0 && ent_q[i].qk == bus.cdb_tag_in[c*ROB_W +: ROB_W]) begin
                  ent_q[i].vk <= bus.cdb_data_in[c*XLEN +: XLEN];
                  ent_q[i].qk <= '0;
                end
              end
            end
          end
        end

        if (disp_acc) begin
          ent_q[free_idx]   <= disp_ent;
          valid_q[free_idx] <= 1'b1;
          older_q[free_idx] <= '0;  // newcomer is younger than everyone
          for (int j = 0; j < DEPTH; j++)
            if (valid_q[j]) older_q[j][free_idx] <= 1'b1;
        end

        if (issue_fire) begin
          valid_q[sel_idx] <= 1'b0;
          iss_q.opcode     <= ent_q[sel_idx].opcode;
          iss_q.vj         <= ent_q[sel_idx].vj;
          iss_q.vk         <= ent_q[sel_idx].vk;
          iss_q.imm        <= ent_q[sel_idx].imm;
          iss_q.pc         <= ent_q[sel_idx].pc;
          iss_q.dest       <= ent_q[sel_idx].dest;
          iss_vld_q        <= 1'b1;
        end else if (bus.issue_ready_in) begin
          iss_vld_q <= 1'b0;
        end

        count_q <= count_d;
        full_q  <= full_d;
        afull_q <= afull_d;
      end
    end
  end

  assign bus.full_out         = full_q;
  assign bus.almost_full_out  = afull_q;
  assign bus.count_out        = count_q;
  assign bus.issue_valid_out  = iss_vld_q;
  assign bus.issue_opcode_out = iss_q.opcode;
  assign bus.issue_vj_out     = iss_q.vj;
  assign bus.issue_vk_out     = iss_q.vk;
  assign bus.issue_imm_out    = iss_q.imm;
  assign bus.issue_pc_out     = iss_q.pc;
  assign bus.issue_dest_out   = iss_q.dest;
endmodule

// File: tb/tb_rs_station_param.sv
// tb_rs_station_param: directed scoreboard bench for rs_station_param.
// Expected issue records are queued at dispatch and checked on each issue handshake.
module tb_rs_station_param;
  localparam int DEPTH = 8, XLEN = 32, ROB_W = 4, OP_W = 6, NUM_CDB = 2, AFULL_TH = 2;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [ROB_W-1:0] dest;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, rdy, flush;
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  rs_station_param_if #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) bus ();

  rs_station_param #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W),
                     .NUM_CDB(NUM_CDB), .AFULL_TH(AFULL_TH)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .flush_in (flush),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cdb(input logic [NUM_CDB-1:0] vld, input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] data, input int ch);
    bus.cdb_valid_in = vld;
    bus.cdb_tag_in   = '0;
    bus.cdb_data_in  = '0;
    bus.cdb_tag_in[ch*ROB_W +: ROB_W] = tag;
    bus.cdb_data_in[ch*XLEN +: XLEN]  = data;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] qj, input logic [ROB_W-1:0] qk,
                      input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk, input logic [ROB_W-1:0] dest,
                      input logic [XLEN-1:0] evj, input logic [XLEN-1:0] evk, input bit push);
    exp_t e;
    bus.disp_opcode_in = op;
    bus.disp_qj_in     = qj;
    bus.disp_qk_in     = qk;
    bus.disp_vj_in     = vj;
    bus.disp_vk_in     = vk;
    bus.disp_imm_in    = 32'h100 + 32'(op);
    bus.disp_pc_in     = 32'h4000 + 32'(op) * 4;
    bus.disp_dest_in   = dest;
    bus.disp_en_in     = 1'b1;
    if (push) begin
      e = '{op: op, vj: evj, vk: evk, imm: 32'h100 + 32'(op), pc: 32'h4000 + 32'(op) * 4, dest: dest};
      sb.push_back(e);
    end
    tick();
    bus.disp_en_in = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk(tag, 64'(sb.size()), 64'(0));
  endtask

  // Scoreboard: a handshake completes at the next posedge when valid & ready are seen here.
  always @(negedge clk) begin
    if (rst_n && rdy && !flush && bus.issue_valid_out && bus.issue_ready_in) begin
      chk("issue_expected", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_opcode", 64'(bus.issue_opcode_out), 64'(e.op));
        chk("issue_vj",     64'(bus.issue_vj_out),     64'(e.vj));
        chk("issue_vk",     64'(bus.issue_vk_out),     64'(e.vk));
        chk("issue_imm",    64'(bus.issue_imm_out),    64'(e.imm));
        chk("issue_pc",     64'(bus.issue_pc_out),     64'(e.pc));
        chk("issue_dest",   64'(bus.issue_dest_out),   64'(e.dest));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.disp_en_in = 1'b0; bus.disp_opcode_in = '0; bus.disp_qj_in = '0; bus.disp_qk_in = '0;
    bus.disp_vj_in = '0; bus.disp_vk_in = '0; bus.disp_imm_in = '0; bus.disp_pc_in = '0;
    bus.disp_dest_in = '0; bus.cdb_valid_in = '0; bus.cdb_tag_in = '0; bus.cdb_data_in = '0;
    bus.issue_ready_in = 1'b0;
    tick(); tick();
    chk("rst_count", 64'(bus.count_out), 64'(0));
    chk("rst_full",  64'(bus.full_out), 64'(0));
    chk("rst_afull", 64'(bus.almost_full_out), 64'(DEPTH <= AFULL_TH));
    chk("rst_vld",   64'(bus.issue_valid_out), 64'(0));
    chk("rst_vj",    64'(bus.issue_vj_out), 64'(0));
    chk("rst_dest",  64'(bus.issue_dest_out), 64'(0));
    rst_n = 1'b1;

    // 1: ready add issues two edges after dispatch
    bus.issue_ready_in = 1'b1;
    disp(6'd1, 4'd0, 4'd0, 32'd5, 32'd7, 4'd3, 32'd5, 32'd7, 1'b1);
    chk("t1_count_e0", 64'(bus.count_out), 64'(1));
    chk("t1_vld_e0",   64'(bus.issue_valid_out), 64'(0));
    tick();
    chk("t1_vld_e1",   64'(bus.issue_valid_out), 64'(1));
    chk("t1_vj",       64'(bus.issue_vj_out), 64'(5));
    chk("t1_vk",       64'(bus.issue_vk_out), 64'(7));
    chk("t1_dest",     64'(bus.issue_dest_out), 64'(3));
    chk("t1_count_e1", 64'(bus.count_out), 64'(0));
    tick();
    chk("t1_vld_idle", 64'(bus.issue_valid_out), 64'(0));

    // 2: two waiters on tag 4, woken by channel 1, issue in age order
    disp(6'd2, 4'd4, 4'd0, 32'd0, 32'd1, 4'd1, 32'h55, 32'd1, 1'b1);
    disp(6'd3, 4'd4, 4'd0, 32'd0, 32'd2, 4'd2, 32'h55, 32'd2, 1'b1);
    chk("t2_wait_vld", 64'(bus.issue_valid_out), 64'(0));
    set_cdb(2'b10, 4'd4, 32'h55, 1);
    tick();
    set_cdb(2'b00, 4'd0, 32'h0, 0);
    chk("t2_count", 64'(bus.count_out), 64'(2));
    wait_drain("t2_drain");

    // 3: capture of a same-cycle broadcast at dispatch
    set_cdb(2'b01, 4'd6, 32'h1234, 0);
    disp(6'd4, 4'd0, 4'd6, 32'd9, 32'd0, 4'd5, 32'd9, 32'h1234, 1'b1);
    set_cdb(2'b00, 4'd0, 32'h0, 0);
    tick();
    chk("t3_vld", 64'(bus.issue_valid_out), 64'(1));
    chk("t3_vk",  64'(bus.issue_vk_out), 64'(32'h1234));
    wait_drain("t3_drain");

    // 4: fill, almost-full/full, wake all, back-pressure then drain one per cycle
    bus.issue_ready_in = 1'b0;
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      disp(6'(8 + k), 4'd2, 4'd0, 32'd0, 32'(k), 4'(k + 1), 32'hBEEF, 32'(k), 1'b1);
      chk("t4_fill_count", 64'(bus.count_out), 64'(k + 1));
      chk("t4_fill_afull", 64'(bus.almost_full_out), 64'((DEPTH - (k + 1)) <= AFULL_TH));
      chk("t4_fill_full",  64'(bus.full_out), 64'((k + 1) == DEPTH));
    end
    set_cdb(2'b01, 4'd2, 32'hBEEF, 0);
    tick();
    set_cdb(2'b00, 4'd0, 32'h0, 0);
    chk("t4_wake_vld",   64'(bus.issue_valid_out), 64'(0));
    chk("t4_wake_count", 64'(bus.count_out), 64'(8));
    tick();
    chk("t4_load_vld",   64'(bus.issue_valid_out), 64'(1));
    chk("t4_load_count", 64'(bus.count_out), 64'(7));
    chk("t4_load_full",  64'(bus.full_out), 64'(0));
    chk("t4_load_afull", 64'(bus.almost_full_out), 64'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_hold_vld",  64'(bus.issue_valid_out), 64'(1));
      chk("t4_hold_vk",   64'(bus.issue_vk_out), 64'(sb[0].vk));
      chk("t4_hold_dest", 64'(bus.issue_dest_out), 64'(sb[0].dest));
    end
    bus.issue_ready_in = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      tick();
      chk("t4_b2b_count", 64'(bus.count_out), 64'(7 - k));
    end
    tick();
    chk("t4_end_vld", 64'(bus.issue_valid_out), 64'(0));
    chk("t4_end_sb",  64'(sb.size()), 64'(0));

    // 5: flush with occupancy 5 and a held issue, concurrent dispatch discarded
    bus.issue_ready_in = 1'b0;
    for (int k = 0; k < 6; k++)
      disp(6'(20 + k), 4'd0, 4'd0, 32'(k), 32'(k + 10), 4'(k), 32'(k), 32'(k + 10), 1'b1);
    chk("t5_pre_count", 64'(bus.count_out), 64'(5));
    chk("t5_pre_vld",   64'(bus.issue_valid_out), 64'(1));
    sb.delete();
    flush = 1'b1;
    disp(6'd30, 4'd0, 4'd0, 32'd1, 32'd1, 4'd9, 32'd1, 32'd1, 1'b0);
    flush = 1'b0;
    chk("t5_count", 64'(bus.count_out), 64'(0));
    chk("t5_vld",   64'(bus.issue_valid_out), 64'(0));
    chk("t5_full",  64'(bus.full_out), 64'(0));
    chk("t5_afull", 64'(bus.almost_full_out), 64'(0));
    bus.issue_ready_in = 1'b1;
    tick(); tick();
    chk("t5_post_count", 64'(bus.count_out), 64'(0));
    chk("t5_post_vld",   64'(bus.issue_valid_out), 64'(0));

    // 6: rdy low freezes state and ignores broadcasts and dispatch
    disp(6'd40, 4'd9, 4'd0, 32'd0, 32'd3, 4'd7, 32'h99, 32'd3, 1'b1);
    chk("t6_pre_count", 64'(bus.count_out), 64'(1));
    rdy = 1'b0;
    set_cdb(2'b01, 4'd9, 32'h77, 0);
    bus.disp_qj_in = '0; bus.disp_qk_in = '0; bus.disp_opcode_in = 6'd41; bus.disp_en_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_frz_count", 64'(bus.count_out), 64'(1));
      chk("t6_frz_vld",   64'(bus.issue_valid_out), 64'(0));
    end
    rdy = 1'b1;
    bus.disp_en_in = 1'b0;
    set_cdb(2'b00, 4'd0, 32'h0, 0);
    tick(); tick();
    chk("t6_post_count", 64'(bus.count_out), 64'(1));
    chk("t6_post_vld",   64'(bus.issue_valid_out), 64'(0));
    chk("t6_post_afull", 64'(bus.almost_full_out), 64'(0));
    set_cdb(2'b01, 4'd9, 32'h99, 0);
    tick();
    set_cdb(2'b00, 4'd0, 32'h0, 0);
    wait_drain("t6_drain");
    tick();
    chk("t6_end_count", 64'(bus.count_out), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
